// File: rtl/pgm_pkg.sv
// Shared types and constants for the PGM generation scheduler.
// Covers the FSM state enum, register map, control-word opcodes and field positions.
package pgm_pkg;

    localparam int CW = 134;

    localparam int TYPE_HI = 133;
    localparam int TYPE_LO = 132;
    localparam int RESP_HI = 127;
    localparam int RESP_LO = 124;
    localparam int OP_HI   = 126;
    localparam int OP_LO   = 124;
    localparam int MID_HI  = 103;
    localparam int MID_LO  = 96;
    localparam int ADDR_HI = 95;
    localparam int ADDR_LO = 64;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    localparam logic [1:0] TYPE_HDR = 2'b01;
    localparam logic [2:0] OP_WR    = 3'b010;
    localparam logic [2:0] OP_RD    = 3'b001;
    localparam logic [3:0] RD_RESP  = 4'b1011;

    localparam logic [31:0] ADDR_CTRL        = 32'h0;
    localparam logic [31:0] ADDR_GAP         = 32'h1;
    localparam logic [31:0] ADDR_PKT_TOTAL   = 32'h2;
    localparam logic [31:0] ADDR_PROBE_EVERY = 32'h3;
    localparam logic [31:0] ADDR_SENT_PKT    = 32'h4;
    localparam logic [31:0] ADDR_SENT_PROBE  = 32'h5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        GAP,
        FIN
    } state_t;

endpackage

// File: rtl/pgm_sched_cfg.sv
// Control-chain endpoint for pgm_sched: decodes control packets, holds the
// configuration registers and turns read requests into response words.
module pgm_sched_cfg
    import pgm_pkg::*;
#(
    parameter logic [7:0] LMID  = 8'd62,
    parameter int         CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW-1:0]    cin_data,
    input  logic             cin_data_wr,
    input  logic             cin_ready,
    output logic [CW-1:0]    cout_data,
    output logic             cout_data_wr,
    input  logic [CNT_W-1:0] sent_pkt,
    input  logic [CNT_W-1:0] sent_probe,
    output logic             enable,
    output logic             soft_rst,
    output logic [CNT_W-1:0] gap,
    output logic [CNT_W-1:0] pkt_total,
    output logic [CNT_W-1:0] probe_every
);

    logic          hit;
    logic          wr_hit;
    logic          rd_hit;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rd_val;
    logic [CW-1:0] fwd;

    assign addr   = cin_data[ADDR_HI:ADDR_LO];
    assign wdata  = cin_data[DATA_HI:DATA_LO];
    assign hit    = cin_data_wr && cin_ready
                 && (cin_data[TYPE_HI:TYPE_LO] == TYPE_HDR)
                 && (cin_data[MID_HI:MID_LO] == LMID);
    assign wr_hit = hit && (cin_data[OP_HI:OP_LO] == OP_WR);
    assign rd_hit = hit && (cin_data[OP_HI:OP_LO] == OP_RD);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_val = '1;
        case (addr)
            ADDR_CTRL:        rd_val = {31'd0, enable};
            ADDR_GAP:         rd_val = 32'(gap);
            ADDR_PKT_TOTAL:   rd_val = 32'(pkt_total);
            ADDR_PROBE_EVERY: rd_val = 32'(probe_every);
            ADDR_SENT_PKT:    rd_val = 32'(sent_pkt);
            ADDR_SENT_PROBE:  rd_val = 32'(sent_probe);
            default:          rd_val = '1;
        endcase
    end

    always_comb begin
        fwd = cin_data;
        if (rd_hit) begin
            fwd[RESP_HI:RESP_LO] = RD_RESP;
            fwd[DATA_HI:DATA_LO] = rd_val;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_data    <= '0;
            cout_data_wr <= 1'b0;
            enable       <= 1'b0;
            soft_rst     <= 1'b0;
            gap          <= '0;
            pkt_total    <= '0;
            probe_every  <= '0;
        end else begin
            cout_data    <= fwd;
            cout_data_wr <= cin_data_wr;
            soft_rst     <= 1'b0;  // single-cycle pulse
            if (wr_hit) begin
                case (addr)
                    ADDR_CTRL: begin
                        enable   <= wdata[0];
                        soft_rst <= wdata[1];
                    end
                    ADDR_GAP:         gap         <= CNT_W'(wdata);
                    ADDR_PKT_TOTAL:   pkt_total   <= CNT_W'(wdata);
                    ADDR_PROBE_EVERY: probe_every <= CNT_W'(wdata);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/pgm_sched.sv
// PGM generation scheduler: paces gen_req pulses with a programmable gap,
// marks periodic latency probes and stops after a programmed packet count.
module pgm_sched
    import pgm_pkg::*;
#(
    parameter logic [7:0] LMID  = 8'd62,
    parameter int         CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] cin_data,
    input  logic          cin_data_wr,
    output logic          cout_ready,
    output logic [CW-1:0] cout_data,
    output logic          cout_data_wr,
    input  logic          cin_ready,
    output logic          gen_req,
    output logic          gen_probe,
    input  logic          gen_done,
    input  logic          out_alf,
    output logic          sched_active,
    output logic          sched_fin
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             enable;
    logic             soft_rst;
    logic [CNT_W-1:0] gap;
    logic [CNT_W-1:0] pkt_total;
    logic [CNT_W-1:0] probe_every;
    logic [CNT_W-1:0] sent_pkt;
    logic [CNT_W-1:0] sent_probe;
    logic [CNT_W-1:0] since_probe;
    logic [CNT_W-1:0] gap_cnt;
    logic             cur_probe;
    logic             probe_now;
    logic             last_pkt;
    state_t           state;
    state_t           state_nxt;

    assign cout_ready = cin_ready;

    pgm_sched_cfg #(
        .LMID  (LMID),
        .CNT_W (CNT_W)
    ) u_cfg (
        .clk          (clk),
        .rst_n        (rst_n),
        .cin_data     (cin_data),
        .cin_data_wr  (cin_data_wr),
        .cin_ready    (cin_ready),
        .cout_data    (cout_data),
        .cout_data_wr (cout_data_wr),
        .sent_pkt     (sent_pkt),
        .sent_probe   (sent_probe),
        .enable       (enable),
        .soft_rst     (soft_rst),
        .gap          (gap),
        .pkt_total    (pkt_total),
        .probe_every  (probe_every)
    );

    assign probe_now    = (probe_every != '0) && (since_probe == probe_every - ONE);
    assign last_pkt     = (pkt_total != '0) && (sent_pkt + ONE == pkt_total);
    assign sched_active = (state == ISSUE) || (state == BUSY) || (state == GAP);
    assign sched_fin    = (state == FIN);

    always_comb begin
        state_nxt = state;
        gen_req   = 1'b0;
        gen_probe = 1'b0;
        case (state)
            IDLE:  if (enable) state_nxt = ISSUE;
            ISSUE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (!out_alf) begin
                    gen_req   = 1'b1;
                    gen_probe = probe_now;
                    state_nxt = BUSY;
                end
            end
            // An in-flight packet always completes; enable is only looked at on gen_done.
            BUSY: begin
                if (gen_done) begin
                    if (last_pkt)     state_nxt = FIN;
                    else if (!enable) state_nxt = IDLE;
                    else              state_nxt = GAP;
                end
            end
            GAP: begin
                if (!enable)             state_nxt = IDLE;
                else if (gap_cnt == '0)  state_nxt = ISSUE;
            end
            FIN:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (soft_rst) begin
            state_nxt = IDLE;
            gen_req   = 1'b0;
            gen_probe = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sent_pkt    <= '0;
            sent_probe  <= '0;
            since_probe <= '0;
            gap_cnt     <= '0;
            cur_probe   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (soft_rst || (state == IDLE && enable)) begin
                sent_pkt    <= '0;
                sent_probe  <= '0;
                since_probe <= '0;
            end else if (state == BUSY && gen_done) begin
                sent_pkt <= sent_pkt + ONE;
                if (cur_probe) begin
                    sent_probe  <= sent_probe + ONE;
                    since_probe <= '0;
                end else begin
                    since_probe <= since_probe + ONE;
                end
            end
            if (gen_req) cur_probe <= gen_probe;
            // Reloaded throughout BUSY so a GAP write lands at the next packet boundary.
            if (state == BUSY)                        gap_cnt <= gap;
            else if (state == GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - ONE;
        end
    end

endmodule

// File: tb/tb_pgm_sched.sv
// Randomized self-checking bench for pgm_sched: the bench plays the read engine and
// predicts request timing, probe marking and counter values from the scheduling rules.
module tb_pgm_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [133:0] cin_data;
    logic         cin_data_wr;
    logic         cout_ready;
    logic [133:0] cout_data;
    logic         cout_data_wr;
    logic         cin_ready;
    logic         gen_req;
    logic         gen_probe;
    logic         gen_done;
    logic         out_alf;
    logic         sched_active;
    logic         sched_fin;

    always #5 clk = ~clk;

    pgm_sched #(.LMID(8'd62), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cin_data     (cin_data),
        .cin_data_wr  (cin_data_wr),
        .cout_ready   (cout_ready),
        .cout_data    (cout_data),
        .cout_data_wr (cout_data_wr),
        .cin_ready    (cin_ready),
        .gen_req      (gen_req),
        .gen_probe    (gen_probe),
        .gen_done     (gen_done),
        .out_alf      (out_alf),
        .sched_active (sched_active),
        .sched_fin    (sched_fin)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: current run parameters and what has been observed so far.
    int           cyc = 0;
    int           done_cd = 0;
    int           lat = 1;
    bit           spur = 1'b0;
    int           m_gap, m_total, m_pe;
    bit           run_on = 1'b0;
    bit           armed = 1'b0;
    int           ready_cyc = 0;
    int           exp_req_cyc = -1;
    int           run_req = 0;
    int           run_done = 0;
    bit           alf_mode = 1'b0;
    bit           alf_force = 1'b0;
    logic [133:0] nxt_word = '0;
    logic         nxt_wr = 1'b0;
    logic [31:0]  rd;

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs just after the rising edge, observe on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cin_data    = nxt_word;
        cin_data_wr = nxt_wr;
        gen_done    = spur;
        spur        = 1'b0;
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) begin
                gen_done = 1'b1;
                run_done++;
                if (run_on && (m_total == 0 || run_done != m_total)) begin
                    armed       = 1'b1;
                    ready_cyc   = cyc + 2 + m_gap;
                    exp_req_cyc = -1;
                end
            end
        end
        out_alf = alf_mode ? ($urandom_range(0, 3) == 0) : alf_force;
        if (armed && exp_req_cyc < 0 && cyc >= ready_cyc && !out_alf) exp_req_cyc = cyc;
        @(negedge clk);
        if (gen_req) begin
            run_req++;
            check("req_while_alf", out_alf, 1'b0);
            if (armed) check("req_cycle", cyc, exp_req_cyc);
            armed = 1'b0;
            check("req_probe", gen_probe, (m_pe != 0 && (run_req % m_pe) == 0));
            done_cd = lat;
        end
    endtask

    function automatic logic [133:0] mk(input logic [2:0] op, input logic [7:0] mid,
                                        input logic [31:0] addr, input logic [31:0] data);
        logic [159:0] r;
        logic [133:0] w;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        w = r[133:0];
        w[133:132] = 2'b01;
        w[126:124] = op;
        w[103:96]  = mid;
        w[95:64]   = addr;
        w[31:0]    = data;
        return w;
    endfunction

    task automatic send(input logic [133:0] w);
        nxt_word = w;
        nxt_wr   = 1'b1;
        tick();
        nxt_word = '0;
        nxt_wr   = 1'b0;
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        send(mk(3'b010, 8'd62, addr, data));
    endtask

    task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
        logic [133:0] w;
        w = mk(3'b001, 8'd62, addr, $urandom());
        send(w);
        tick();
        check("rd_valid", cout_data_wr, 1'b1);
        check("rd_header", cout_data[133:32], {w[133:128], 4'b1011, w[123:32]});
        data = cout_data[31:0];
    endtask

    task automatic start_run(input int g, input int total, input int pe, input int l);
        cfg_write(32'h1, g);
        cfg_write(32'h2, total);
        cfg_write(32'h3, pe);
        m_gap = g; m_total = total; m_pe = pe; lat = l;
        run_req = 0; run_done = 0; run_on = 1'b1;
        cfg_write(32'h0, 32'h1);
        armed = 1'b1; ready_cyc = cyc + 2; exp_req_cyc = -1;
    endtask

    task automatic stop_run();
        cfg_write(32'h0, 32'h0);
        run_on = 1'b0;
        armed  = 1'b0;
    endtask

    // Runs to completion and checks the finished-run state and counters.
    task automatic finish_run();
        for (int i = 0; i < 3000 && run_done != m_total; i++) tick();
        check("run_done_count", run_done, m_total);
        repeat (3) tick();
        check("fin_set", sched_fin, 1'b1);
        check("fin_inactive", sched_active, 1'b0);
        spur = 1'b1;
        repeat (10) tick();
        check("req_total", run_req, m_total);
        cfg_read(32'h4, rd);
        check("sent_pkt", rd, m_total);
        cfg_read(32'h5, rd);
        check("sent_probe", rd, (m_pe == 0) ? 0 : m_total / m_pe);
        stop_run();
        repeat (3) tick();
        check("fin_clear", sched_fin, 1'b0);
    endtask

    initial begin
        logic [133:0] w;
        rst_n = 1'b0; cin_data = '0; cin_data_wr = 1'b0; cin_ready = 1'b1;
        gen_done = 1'b0; out_alf = 1'b0;
        #2;
        check("rst_gen_req", gen_req, 1'b0);
        check("rst_gen_probe", gen_probe, 1'b0);
        check("rst_active", sched_active, 1'b0);
        check("rst_fin", sched_fin, 1'b0);
        check("rst_cout_wr", cout_data_wr, 1'b0);
        check("rst_cout_data", cout_data, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cin_ready = 1'b0; #1;
        check("ready_low", cout_ready, 1'b0);
        cin_ready = 1'b1; #1;
        check("ready_high", cout_ready, 1'b1);
        cfg_read(32'h4, rd);
        check("rst_sent_pkt", rd, 0);
        cfg_read(32'h1, rd);
        check("rst_gap", rd, 0);

        start_run(5, 3, 0, 4);
        finish_run();
        start_run(2, 10, 4, 3);
        finish_run();

        for (int r = 0; r < 6; r++) begin
            alf_mode = $urandom_range(0, 1);
            start_run($urandom_range(0, 5), $urandom_range(1, 9), $urandom_range(0, 4),
                      $urandom_range(1, 4));
            finish_run();
        end
        alf_mode = 1'b0;

        // Almost-full held while the run sits in ISSUE.
        alf_force = 1'b1;
        start_run(1, 2, 0, 2);
        repeat (20) tick();
        check("alf_no_req", run_req, 0);
        check("alf_active", sched_active, 1'b1);
        alf_force = 1'b0;
        finish_run();

        // Enable cleared while a packet is in flight.
        start_run(3, 0, 0, 6);
        for (int i = 0; i < 50 && run_req == 0; i++) tick();
        stop_run();
        repeat (30) tick();
        check("dis_req_count", run_req, 1);
        check("dis_done_count", run_done, 1);
        check("dis_inactive", sched_active, 1'b0);
        cfg_read(32'h4, rd);
        check("dis_sent_pkt", rd, 1);

        // Soft reset during the gap with enable left on.
        start_run(8, 50, 0, 2);
        for (int i = 0; i < 50 && run_done == 0; i++) tick();
        repeat (2) tick();
        lat = 10;
        cfg_write(32'h0, 32'h3);
        run_req = 0; run_done = 0; armed = 1'b0;
        tick();
        cfg_read(32'h4, rd);
        check("srst_sent_pkt", rd, 0);
        cfg_read(32'h5, rd);
        check("srst_sent_probe", rd, 0);
        cfg_read(32'h1, rd);
        check("srst_gap_kept", rd, 8);
        cfg_read(32'h2, rd);
        check("srst_total_kept", rd, 50);
        cfg_read(32'h0, rd);
        check("srst_ctrl", rd, 1);
        for (int i = 0; i < 80 && run_req < 2; i++) tick();
        check("srst_restart", run_req >= 2, 1'b1);
        stop_run();
        repeat (20) tick();

        // Register access and control-chain passthrough.
        cfg_write(32'h1, 32'h0000002A);
        cfg_read(32'h1, rd);
        check("rd_gap_2a", rd, 32'h2A);
        cfg_read(32'h7, rd);
        check("rd_unknown", rd, 32'hFFFFFFFF);
        w = mk(3'b001, 8'd61, 32'h1, $urandom());
        send(w);
        tick();
        check("other_mid_wr", cout_data_wr, 1'b1);
        check("other_mid_data", cout_data, w);
        w = mk(3'b010, 8'd62, 32'h3, 32'h5);
        send(w);
        tick();
        check("write_fwd", cout_data, w);
        w = mk(3'b001, 8'd62, 32'h1, $urandom());
        w[133:132] = 2'b10;
        send(w);
        tick();
        check("nonhdr_fwd", cout_data, w);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/pgm_sched.md
Name: pgm_sched

Overview:
- Generation scheduler for the packet generator (PGM) read path.
- Decides when the PGM read engine emits the stored packet, which emissions are latency probes, and when the run finishes.
- Paces emissions with a programmable inter-packet gap and stops after a programmed packet count.
- Sits on the configuration-packet chain between DMA and the PGM read engine; registers are accessed by control packets addressed to its MID.

Parameters:
- LMID, 8'd62, MID this block answers on the control chain (cin_data[103:96]).
- CNT_W, 32, width of all config/status counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cin_data  in  134  control packet word from upstream
- cin_data_wr  in  1  control word valid
- cout_ready  out  1  ready to upstream, equal to cin_ready combinationally
- cout_data  out  134  control word to next module
- cout_data_wr  out  1  control word valid to next module
- cin_ready  in  1  ready from next module
- gen_req  out  1  one-cycle pulse: read engine starts one packet
- gen_probe  out  1  qualifies gen_req: this packet is a probe
- gen_done  in  1  one-cycle pulse: read engine finished a packet (last word out)
- out_alf  in  1  downstream almost-full; blocks new gen_req
- sched_active  out  1  run in progress
- sched_fin  out  1  run completed, held until enable cleared

Behaviour:
- Reset: all outputs 0; config regs 0; counters 0; state IDLE.
- Register map (cin_data[95:64]):
  - 0x0 CTRL: bit0 enable, bit1 soft_rst (self-clearing, reads 0).
  - 0x1 GAP.
  - 0x2 PKT_TOTAL (0 = unlimited).
  - 0x3 PROBE_EVERY (0 = no probes).
  - 0x4 SENT_PKT (RO).
  - 0x5 SENT_PROBE (RO).
- Control path: one-cycle registered passthrough of cin_data/cin_data_wr.
  - Header word = cin_data[133:132]==2'b01 with cin_data_wr && cin_ready.
  - Write: MID==LMID and op cin_data[126:124]==3'b010 → reg updated from cin_data[31:0] at the same edge; word forwarded unchanged.
  - Read: op==3'b001 → forwarded as {cin_data[133:128], 4'b1011, cin_data[123:32], value}. Unknown or RO-miss addresses return 32'hFFFFFFFF.
  - Other MIDs, and non-header words, forwarded unchanged.
- FSM states: IDLE, ISSUE, BUSY, GAP, FIN.
  - IDLE: when enable==1, clear SENT_PKT, SENT_PROBE and since_probe, then go to ISSUE. sched_active=0.
  - ISSUE: if out_alf, hold with no pulse. Else assert gen_req for one cycle, with gen_probe = (PROBE_EVERY!=0 && since_probe==PROBE_EVERY-1), then go to BUSY. sched_active=1 in ISSUE, BUSY and GAP.
  - BUSY: wait for gen_done. On gen_done:
    - SENT_PKT+1.
    - If the packet was a probe: SENT_PROBE+1 and since_probe=0; else since_probe+1.
    - If PKT_TOTAL!=0 and the new SENT_PKT==PKT_TOTAL, go to FIN.
    - Else if enable==0, go to IDLE.
    - Else load gap_cnt=GAP and go to GAP.
  - GAP: decrement gap_cnt each cycle; at 0 go to ISSUE. Timing contract: gen_done high in cycle T, no out_alf → gen_req high in cycle T+2+GAP.
  - FIN: sched_fin=1, no gen_req. When enable==0, go to IDLE and clear sched_fin.
- enable cleared in ISSUE or GAP → IDLE immediately, no pulse. Cleared in BUSY → current packet completes first; packets are never truncated.
- soft_rst=1: state→IDLE, counters and since_probe cleared, gen_req and gen_probe deasserted next cycle. Config regs and enable keep their values, so with enable still set the run restarts.
- gen_done outside BUSY: ignored.
- Counters wrap modulo 2^CNT_W; no saturation.
- A GAP or PROBE_EVERY write mid-run takes effect at the next load/compare.
- A PKT_TOTAL write below the current SENT_PKT: the run continues until wrap equality. Software must stop the run first.

Decomposition:
- Package pgm_pkg holds:
  - FSM state enum.
  - Register address constants.
  - Op codes 3'b010 / 3'b001 and read-response nibble 4'b1011.
  - Control-word field positions (type [133:132], op [126:124], MID [103:96], addr [95:64], data [31:0]).
- One sub-module, pgm_sched_cfg: control-packet decode, register file, read-response mux. The FSM stays in pgm_sched.

Test Plan:
- Write GAP=5, PKT_TOTAL=3, PROBE_EVERY=0, then CTRL=1; answer each gen_req with gen_done 4 cycles later → exactly 3 gen_req with gen_done→gen_req spacing of 7 cycles, sched_fin=1, SENT_PKT reads 3.
- PROBE_EVERY=4, PKT_TOTAL=10 → gen_probe on packets 4 and 8 only, SENT_PROBE reads 2.
- out_alf high for 20 cycles while in ISSUE → no gen_req during those cycles; gen_req is the cycle after out_alf falls.
- Clear enable while BUSY → no further gen_req after the pending gen_done; state returns to IDLE with sched_active=0.
- soft_rst mid-GAP with enable=1 → counters read 0, GAP/PKT_TOTAL retained, new run starts.
- Read 0x1 after writing 0x0000002A → response word has [127:124]=4'b1011 and [31:0]=0x2A. Read address 0x7 → 0xFFFFFFFF. MID 8'd61 packet passes through unchanged one cycle later.
